// File: rtl/mem_wb_if.sv
// MEM->WB handshake bundle: MEM-stage results and pipeline control in, regfile write port and status out.
interface mem_wb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              stall;
  logic              flush;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_alu;
  logic [2:0]        mem_load_op;
  logic [1:0]        mem_addr_lo;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_misalign;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output stall, flush, mem_valid, mem_we, mem_waddr, mem_alu,
           mem_load_op, mem_addr_lo, mem_rdata,
    input  wb_valid, wb_we, wb_waddr, wb_wdata, wb_misalign, retire_cnt
  );

  modport slave (
    input  stall, flush, mem_valid, mem_we, mem_waddr, mem_alu,
           mem_load_op, mem_addr_lo, mem_rdata,
    output wb_valid, wb_we, wb_waddr, wb_wdata, wb_misalign, retire_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with big-endian load formatting, misalign flagging and retire counting.
// One-cycle latency; stall holds every WB output, flush inserts a bubble and wins over stall.
module mem_wb_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input logic    clk,
  input logic    rst,
  mem_wb_if.slave bus
);

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;

  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] fmt_data;
  logic              misalign;
  logic              wr_en;
  logic              retire;

  logic              valid_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              misalign_q;
  logic [CNT_W-1:0]  cnt_q;

  // Lane 0 is the most significant byte of the word.
  always_comb begin
    byte_lane = 8'h00;
    case (bus.mem_addr_lo)
      2'd0: byte_lane = bus.mem_rdata[31:24];
      2'd1: byte_lane = bus.mem_rdata[23:16];
      2'd2: byte_lane = bus.mem_rdata[15:8];
      2'd3: byte_lane = bus.mem_rdata[7:0];
      default: byte_lane = 8'h00;
    endcase
  end

  assign half_lane = bus.mem_addr_lo[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];

  always_comb begin
    fmt_data = bus.mem_alu;
    case (bus.mem_load_op)
      OP_LB:   fmt_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      OP_LBU:  fmt_data = {{(DATA_W-8){1'b0}}, byte_lane};
      OP_LH:   fmt_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
      OP_LHU:  fmt_data = {{(DATA_W-16){1'b0}}, half_lane};
      OP_LW:   fmt_data = bus.mem_rdata;
      default: fmt_data = bus.mem_alu;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    case (bus.mem_load_op)
      OP_LH, OP_LHU: misalign = bus.mem_addr_lo[0];
      OP_LW:         misalign = (bus.mem_addr_lo != 2'd0);
      default:       misalign = 1'b0;
    endcase
  end

  // Misaligned loads still occupy WB (for the trap path) but never write or retire.
  assign wr_en  = bus.mem_valid & bus.mem_we & (|bus.mem_waddr) & ~misalign;
  assign retire = bus.mem_valid & ~misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else if (bus.flush) begin
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q    <= bus.mem_valid;
      we_q       <= wr_en;
      waddr_q    <= bus.mem_waddr;
      wdata_q    <= fmt_data;
      misalign_q <= bus.mem_valid & misalign;
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.wb_valid    = valid_q;
  assign bus.wb_we       = we_q;
  assign bus.wb_waddr    = waddr_q;
  assign bus.wb_wdata    = wdata_q;
  assign bus.wb_misalign = misalign_q;
  assign bus.retire_cnt  = cnt_q;

endmodule
